mips_mdu: RTL and testbench

MIPS_MDU -- requirements
Module: mips_mdu

---
 rtl/mips_mdu.sv | 203 ++++++++++++++++++++
 tb/tb_mips_mdu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mdu.sv
// MIPS multiply/divide unit: iterative shift-add multiply and restoring divide
// over WIDTH cycles, with HI/LO result registers and MTHI/MTLO moves.
module mips_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    op_e              op_in;
    logic             in_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic             is_mul;
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_mq;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic             mul_neg;
    logic             quo_neg;
    logic             rem_neg;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Operands are reduced to magnitudes at acceptance; signs are restored from a_q/b_q at the end.
    always_comb begin
        op_in     = op_e'(op);
        in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
        a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        is_mul     = (op_q == OP_MULT) || (op_q == OP_MULTU);
        mul_addend = mq_q[0] ? mcand_q : '0;
        mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
        div_diff   = {acc_q, mq_q[WIDTH-1]} - {1'b0, mcand_q};
        step_acc   = acc_q;
        step_mq    = mq_q;

        if (is_mul) begin
            step_acc = mul_sum[WIDTH:1];
            step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_acc = div_diff[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
            step_mq  = {mq_q[WIDTH-2:0], 1'b0};
        end

        product     = {step_acc, step_mq};
        mul_neg     = (op_q == OP_MULT) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        product_fix = mul_neg ? -product : product;
        quo_neg     = (op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rem_neg     = (op_q == OP_DIV) && a_q[WIDTH-1];

        if (is_mul) begin
            res_hi = product_fix[2*WIDTH-1:WIDTH];
            res_lo = product_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else if ((op_q == OP_DIV) && (a_q == MOST_NEG) && (b_q == '1)) begin
            res_hi = '0;
            res_lo = a_q;
        end else begin
            res_hi = rem_neg ? -step_acc : step_acc;
            res_lo = quo_neg ? -step_mq : step_mq;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            op_d    = op_in;
                            a_d     = a;
                            b_d     = b;
                            acc_d   = '0;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = ST_RUN;
                            if ((op_in == OP_MULT) || (op_in == OP_MULTU)) begin
                                mcand_d = a_mag;
                                mq_d    = b_mag;
                            end else begin
                                mcand_d = b_mag;
                                mq_d    = a_mag;
                            end
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed-vector bench for mips_mdu at WIDTH=32 with hand-computed HI/LO values.
module tb_mips_mdu;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         saw_done;

    mips_mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge in cycle k+1, where k is the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int c0,
                             input logic [W-1:0] eh, input logic [W-1:0] el);
        int cyc;
        cyc = c0;
        while (done !== 1'b1 && cyc < int'(W) + 8) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, W + 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_fin"}, busy, 1);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
        issue(o, x, y);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_hi_hold"}, hi, m_hi);
        check({tag, "_lo_hold"}, lo, m_lo);
        wait_done(tag, 1, eh, el);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        run("mult_m2x3",   3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run("multu_max",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("div_m7_2",    3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu_by0",    3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run("div_ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run("div_7_m2",    3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run("div_m8_m3",   3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002);
        run("div_by0_sgn", 3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run("divu_100_7",  3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
        run("mult_7xm5",   3'd0, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD);
        run("mult_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // MTHI pulsed mid-flight and operand changes during RUN must not disturb the MULT.
        issue(3'd0, 32'h0000_0010, 32'h0000_0020);
        check("inflt_busy", busy, 1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0005;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        check("inflt_hi_hold", hi, m_hi);
        wait_done("inflt_mult", 6, 32'h0000_0000, 32'h0000_0200);

        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        a     = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h0000_1234);
        check("mtlo_hi", hi, 32'h0000_0000);
        check("mtlo_busy", busy, 0);
        check("mtlo_done", done, 0);

        start = 1'b1;
        op    = 3'd4;
        a     = 32'h0000_ABCD;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", hi, 32'h0000_ABCD);
        check("mthi_lo", lo, 32'h0000_1234);
        check("mthi_busy", busy, 0);

        start = 1'b1;
        op    = 3'd6;
        a     = 32'h5555_5555;
        b     = 32'h0000_0003;
        @(negedge clk);
        op    = 3'd7;
        @(negedge clk);
        start = 1'b0;
        check("rsv_hi", hi, 32'h0000_ABCD);
        check("rsv_lo", lo, 32'h0000_1234);
        check("rsv_busy", busy, 0);
        check("rsv_done", done, 0);
        m_hi = 32'h0000_ABCD;
        m_lo = 32'h0000_1234;

        // Reset lands on the edge closing cycle k+10 of a DIVU.
        issue(3'd3, 32'h0000_0064, 32'h0000_0007);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        m_hi = '0;
        m_lo = '0;

        run("multu_2p32", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        run("multu_x10",  3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
